pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer between the execute stage and the IF/ID/EX pipeline registers.
- Turns execute-stage jump/hold requests, load-use hazards and multi-cycle MUL/DIV unit (MDU) operations into PC redirect, stall, flush and bubble controls.
- Owns the MDU start/done handshake, an MDU timeout, and a stall performance counter.

Parameters:
- MDU_TIMEOUT, 64, cycles in MDU_WAIT before forced abort; legal range 2..65535.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- jump_en_i  in  1  branch/jump taken, from execute
- jump_addr_i  in  32  redirect target, from execute
- hold_flag_i  in  1  generic hold request, from execute
- mdu_req_i  in  1  level; EX holds a multi-cycle op
- mdu_done_i  in  1  MDU result valid this cycle
- ex_mem_re_i  in  1  EX instruction is a load
- ex_rd_addr_i  in  5  EX destination register
- id_rs1_addr_i  in  5  ID source register 1
- id_rs2_addr_i  in  5  ID source register 2
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- pc_load_o  out  1  PC loads pc_load_addr_o
- pc_load_addr_o  out  32  redirect target
- pc_hold_o  out  1  freeze PC
- if_id_hold_o  out  1  freeze IF/ID
- if_id_flush_o  out  1  load NOP into IF/ID
- id_ex_hold_o  out  1  freeze ID/EX
- id_ex_flush_o  out  1  load NOP into ID/EX
- ex_mem_bubble_o  out  1  EX/MEM captures NOP
- mdu_start_o  out  1  one-cycle MDU start pulse
- mdu_err_o  out  1  one-cycle timeout pulse
- stall_cnt_o  out  CNT_W  count of cycles with pc_hold_o=1

Behaviour:
- Registered state: state {RUN, MDU_WAIT}, tmo_cnt (16 bit), stall_cnt_o. All other outputs are combinational from state and inputs.
- Reset, asynchronous, applies at any time including mid-MDU:
  - state=RUN, tmo_cnt=0, stall_cnt_o=0.
  - With all inputs at 0, every output is 0 and pc_load_addr_o=0.
- Outputs not asserted by a rule below are 0. pc_load_addr_o=0 whenever pc_load_o=0.
- RUN priority, highest first:
  1. jump_en_i=1: pc_load_o=1, pc_load_addr_o=jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1. Applies the same cycle. Overrides all holds.
  2. mdu_req_i=1: mdu_start_o=1; pc_hold, if_id_hold, id_ex_hold, ex_mem_bubble all 1. Next state MDU_WAIT, tmo_cnt<=0.
  3. hold_flag_i=1: pc_hold, if_id_hold, id_ex_hold, ex_mem_bubble all 1.
  4. Load-use hazard: pc_hold=1, if_id_hold=1, id_ex_flush=1. Exactly one bubble; the hazard clears naturally the next cycle.
     - Hazard = ex_mem_re_i & (ex_rd_addr_i!=0) & ((id_rs1_used_i & rs1==ex_rd_addr_i) | (id_rs2_used_i & rs2==ex_rd_addr_i)).
- mdu_done_i is ignored in RUN.
- MDU_WAIT:
  - mdu_done_i=1: all holds and bubble 0 this cycle (EX/MEM captures the MDU result); next state RUN.
  - Else if tmo_cnt==MDU_TIMEOUT-1: mdu_err_o=1, ex_mem_bubble_o=1, holds 0 (instruction dropped); next state RUN.
  - Else: pc_hold, if_id_hold, id_ex_hold, ex_mem_bubble all 1; tmo_cnt increments.
  - jump_en_i, hold_flag_i and the load-use hazard are ignored in MDU_WAIT.
  - mdu_start_o=0 in MDU_WAIT.
- Minimum MDU stall: 2 cycles (start cycle plus done cycle).
- Back-to-back MDU ops: a new start is issued in the first RUN cycle if mdu_req_i is still high (the next instruction has moved into EX).
- stall_cnt_o: +1 on every clock edge where pc_hold_o=1; wraps modulo 2^CNT_W.

Decomposition:
- Add to the shared defines.v include: state encodings `PCTRL_RUN=1'b0, `PCTRL_MDU_WAIT=1'b1.
- Add to the shared defines.v include: `ZERO_REG=5'd0.
- One sub-module: load_use_det, purely combinational; produces the hazard bit from the ex_/id_ register and used signals.

Test Plan:
- Reset with all inputs 0 -> all outputs 0, stall_cnt_o=0. Assert rst_n=0 while in MDU_WAIT -> immediate return to RUN, holds drop without a clock.
- RUN, jump_en_i=1, jump_addr_i=32'h0000_0100 -> same cycle pc_load_o=1, addr=0x100, if_id_flush_o=1, id_ex_flush_o=1, no hold; also check jump_en_i with hazard present -> jump wins.
- ex_mem_re_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, id_rs2_used_i=1 for one cycle -> pc_hold=1, if_id_hold=1, id_ex_flush=1 for 1 cycle; repeat with ex_rd_addr_i=0 -> no stall.
- mdu_req_i=1, mdu_done_i=1 three cycles later -> mdu_start_o pulses once; holds for 3 cycles; cycle 4 holds=0 and bubble=0; stall_cnt_o=3.
- MDU_TIMEOUT=4, mdu_req_i=1, never done -> mdu_err_o pulses in the 4th MDU_WAIT cycle with ex_mem_bubble_o=1; state returns to RUN; new mdu_start_o next cycle if mdu_req_i is still 1.
- Drive stall_cnt_o to 2^CNT_W-1 (CNT_W=4), apply hold_flag_i=1 for 2 cycles -> counter wraps 15->0->1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic {
        PCTRL_RUN      = 1'b0,
        PCTRL_MDU_WAIT = 1'b1
    } pctrl_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam int         TMO_W    = 16;

    typedef struct packed {
        logic pc_load;
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_hold;
        logic id_ex_flush;
        logic ex_mem_bubble;
        logic mdu_start;
        logic mdu_err;
    } ctrl_t;

    // Full freeze of PC, IF/ID and ID/EX with a NOP pushed into EX/MEM.
    function automatic ctrl_t ctrl_freeze_all(input ctrl_t c);
        ctrl_t r;
        r               = c;
        r.pc_hold       = 1'b1;
        r.if_id_hold    = 1'b1;
        r.id_ex_hold    = 1'b1;
        r.ex_mem_bubble = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_load_use_det.sv
// Load-use hazard detector: EX load whose destination is read by the ID instruction.
// Latency: combinational.
// Backpressure: none; pure decode of register addresses.
import pipe_ctrl_pkg::*;

module load_use_det (
    input  logic       ex_mem_re,
    input  logic [4:0] ex_rd_addr,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used && (id_rs1_addr == ex_rd_addr);
    assign rs2_hit = id_rs2_used && (id_rs2_addr == ex_rd_addr);

    // x0 is never written, so a load into it cannot create a dependency.
    assign hazard = ex_mem_re && (ex_rd_addr != ZERO_REG) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: jump/hold/load-use/MDU requests to PC and pipe-register controls.
// Latency: controls are combinational same-cycle; state, timeout and stall counter are registered.
// Backpressure: holds freeze upstream stages; MDU wait stalls until done or timeout abort.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_flag_i,
    input  logic             mdu_req_i,
    input  logic             mdu_done_i,
    input  logic             ex_mem_re_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    output logic             pc_load_o,
    output logic [31:0]      pc_load_addr_o,
    output logic             pc_hold_o,
    output logic             if_id_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_hold_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_bubble_o,
    output logic             mdu_start_o,
    output logic             mdu_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MDU_TIMEOUT - 1);

    pctrl_state_e     state;
    pctrl_state_e     state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nxt;
    logic             hazard;
    ctrl_t            ctl;

    load_use_det u_load_use_det (
        .ex_mem_re   (ex_mem_re_i),
        .ex_rd_addr  (ex_rd_addr_i),
        .id_rs1_addr (id_rs1_addr_i),
        .id_rs2_addr (id_rs2_addr_i),
        .id_rs1_used (id_rs1_used_i),
        .id_rs2_used (id_rs2_used_i),
        .hazard      (hazard)
    );

    always_comb begin
        ctl         = '0;
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        case (state)
            PCTRL_RUN: begin
                if (jump_en_i) begin
                    ctl.pc_load     = 1'b1;
                    ctl.if_id_flush = 1'b1;
                    ctl.id_ex_flush = 1'b1;
                end else if (mdu_req_i) begin
                    ctl           = ctrl_freeze_all(ctl);
                    ctl.mdu_start = 1'b1;
                    state_nxt     = PCTRL_MDU_WAIT;
                    tmo_cnt_nxt   = '0;
                end else if (hold_flag_i) begin
                    ctl = ctrl_freeze_all(ctl);
                end else if (hazard) begin
                    ctl.pc_hold     = 1'b1;
                    ctl.if_id_hold  = 1'b1;
                    ctl.id_ex_flush = 1'b1;
                end
            end
            PCTRL_MDU_WAIT: begin
                if (mdu_done_i) begin
                    state_nxt = PCTRL_RUN;
                end else if (tmo_cnt == TMO_LAST) begin
                    // Abort: drop the stuck instruction by bubbling EX/MEM and release the pipe.
                    ctl.mdu_err       = 1'b1;
                    ctl.ex_mem_bubble = 1'b1;
                    state_nxt         = PCTRL_RUN;
                end else begin
                    ctl         = ctrl_freeze_all(ctl);
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end
            default: state_nxt = PCTRL_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PCTRL_RUN;
            tmo_cnt     <= '0;
            stall_cnt_o <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (ctl.pc_hold) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

    assign pc_load_o       = ctl.pc_load;
    assign pc_load_addr_o  = ctl.pc_load ? jump_addr_i : 32'd0;
    assign pc_hold_o       = ctl.pc_hold;
    assign if_id_hold_o    = ctl.if_id_hold;
    assign if_id_flush_o   = ctl.if_id_flush;
    assign id_ex_hold_o    = ctl.id_ex_hold;
    assign id_ex_flush_o   = ctl.id_ex_flush;
    assign ex_mem_bubble_o = ctl.ex_mem_bubble;
    assign mdu_start_o     = ctl.mdu_start;
    assign mdu_err_o       = ctl.mdu_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a cycle-count reference model.
module tb_pipe_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_en_i, hold_flag_i, mdu_req_i, mdu_done_i, ex_mem_re_i;
    logic [31:0] jump_addr_i;
    logic [4:0]  ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i;
    logic        id_rs1_used_i, id_rs2_used_i;
    logic        pc_load_o, pc_hold_o, if_id_hold_o, if_id_flush_o;
    logic        id_ex_hold_o, id_ex_flush_o, ex_mem_bubble_o, mdu_start_o, mdu_err_o;
    logic [31:0] pc_load_addr_o;
    logic [CW-1:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
        .mdu_req_i(mdu_req_i), .mdu_done_i(mdu_done_i), .ex_mem_re_i(ex_mem_re_i),
        .ex_rd_addr_i(ex_rd_addr_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .pc_load_o(pc_load_o), .pc_load_addr_o(pc_load_addr_o), .pc_hold_o(pc_hold_o),
        .if_id_hold_o(if_id_hold_o), .if_id_flush_o(if_id_flush_o), .id_ex_hold_o(id_ex_hold_o),
        .id_ex_flush_o(id_ex_flush_o), .ex_mem_bubble_o(ex_mem_bubble_o),
        .mdu_start_o(mdu_start_o), .mdu_err_o(mdu_err_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-MDU flag, cycles already spent waiting, stall total.
    bit          m_mdu, n_mdu;
    int          m_wait, n_wait;
    int          m_stall;
    bit          haz, e_load, e_ph, e_ifh, e_iff, e_idh, e_idf, e_bub, e_start, e_err;
    logic [31:0] e_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_mdu = 0; m_wait = 0; m_stall = 0;
        end
        {e_load, e_ph, e_ifh, e_iff, e_idh, e_idf, e_bub, e_start, e_err} = '0;
        e_addr = 32'd0;
        n_mdu  = m_mdu;
        n_wait = m_wait;
        haz = ex_mem_re_i && ex_rd_addr_i != 0 &&
              ((id_rs1_used_i && id_rs1_addr_i == ex_rd_addr_i) ||
               (id_rs2_used_i && id_rs2_addr_i == ex_rd_addr_i));
        if (!m_mdu) begin
            if (jump_en_i) begin
                e_load = 1; e_addr = jump_addr_i; e_iff = 1; e_idf = 1;
            end else if (mdu_req_i) begin
                e_start = 1; {e_ph, e_ifh, e_idh, e_bub} = '1; n_mdu = 1; n_wait = 0;
            end else if (hold_flag_i) begin
                {e_ph, e_ifh, e_idh, e_bub} = '1;
            end else if (haz) begin
                e_ph = 1; e_ifh = 1; e_idf = 1;
            end
        end else if (mdu_done_i) begin
            n_mdu = 0;
        end else if (m_wait == TMO - 1) begin
            e_err = 1; e_bub = 1; n_mdu = 0;
        end else begin
            {e_ph, e_ifh, e_idh, e_bub} = '1; n_wait = m_wait + 1;
        end
        chk("m_pc_load", pc_load_o, e_load);
        chk("m_pc_load_addr", pc_load_addr_o, e_addr);
        chk("m_pc_hold", pc_hold_o, e_ph);
        chk("m_if_id_hold", if_id_hold_o, e_ifh);
        chk("m_if_id_flush", if_id_flush_o, e_iff);
        chk("m_id_ex_hold", id_ex_hold_o, e_idh);
        chk("m_id_ex_flush", id_ex_flush_o, e_idf);
        chk("m_ex_mem_bubble", ex_mem_bubble_o, e_bub);
        chk("m_mdu_start", mdu_start_o, e_start);
        chk("m_mdu_err", mdu_err_o, e_err);
        chk("m_stall_cnt", stall_cnt_o, 64'(m_stall));
        if (rst_n) begin
            m_mdu  = n_mdu;
            m_wait = n_wait;
            if (e_ph) m_stall = (m_stall + 1) % (1 << CW);
        end
    end

    task automatic clr();
        jump_en_i = 0; jump_addr_i = 0; hold_flag_i = 0; mdu_req_i = 0; mdu_done_i = 0;
        ex_mem_re_i = 0; ex_rd_addr_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        id_rs1_used_i = 0; id_rs2_used_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        clr();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        clr();
        rst_n = 0;
        #3;
        chk("rst_pc_hold", pc_hold_o, 0);
        chk("rst_pc_load", pc_load_o, 0);
        chk("rst_addr", pc_load_addr_o, 0);
        chk("rst_bubble", ex_mem_bubble_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        step();
        rst_n = 1;

        // Jump redirect, then jump alongside a load-use hazard.
        jump_en_i = 1; jump_addr_i = 32'h0000_0100; #1;
        chk("jmp_load", pc_load_o, 1);
        chk("jmp_addr", pc_load_addr_o, 32'h100);
        chk("jmp_flush", {if_id_flush_o, id_ex_flush_o}, 2'b11);
        chk("jmp_nohold", pc_hold_o, 0);
        step();
        ex_mem_re_i = 1; ex_rd_addr_i = 5; id_rs2_addr_i = 5; id_rs2_used_i = 1; #1;
        chk("jmp_haz_load", pc_load_o, 1);
        chk("jmp_haz_nohold", pc_hold_o, 0);
        step();
        jump_en_i = 0; #1;
        chk("haz_stall", {pc_hold_o, if_id_hold_o, id_ex_flush_o, id_ex_hold_o}, 4'b1110);
        step();
        ex_rd_addr_i = 0; id_rs2_addr_i = 0; #1;
        chk("haz_x0", pc_hold_o, 0);
        step();
        clr();

        // MDU op finishing after three stall cycles.
        do_reset();
        mdu_req_i = 1; #1;
        chk("mdu_start", {mdu_start_o, pc_hold_o}, 2'b11);
        step();
        chk("mdu_w1", {mdu_start_o, pc_hold_o, ex_mem_bubble_o}, 3'b011);
        step();
        chk("mdu_w2", pc_hold_o, 1);
        step();
        mdu_done_i = 1; #1;
        chk("mdu_done", {pc_hold_o, if_id_hold_o, id_ex_hold_o, ex_mem_bubble_o}, 4'b0000);
        step();
        mdu_req_i = 0; mdu_done_i = 0;
        chk("mdu_stall_cnt", stall_cnt_o, 3);

        // Timeout abort and immediate restart, then async reset mid-wait.
        do_reset();
        mdu_req_i = 1;
        for (int i = 1; i <= TMO; i++) begin
            step();
            chk("tmo_wait", {mdu_err_o, pc_hold_o}, (i == TMO) ? 2'b10 : 2'b01);
        end
        chk("tmo_bubble", ex_mem_bubble_o, 1);
        step();
        chk("tmo_restart", mdu_start_o, 1);
        step();
        mdu_req_i = 0; #1;
        chk("arst_pre", pc_hold_o, 1);
        rst_n = 0; #1;
        chk("arst_holds", {pc_hold_o, if_id_hold_o, id_ex_hold_o, ex_mem_bubble_o}, 4'b0000);
        chk("arst_cnt", stall_cnt_o, 0);
        step();
        rst_n = 1;

        // Stall counter wrap.
        hold_flag_i = 1;
        for (int i = 0; i < 15; i++) step();
        chk("wrap_15", stall_cnt_o, 15);
        step();
        chk("wrap_0", stall_cnt_o, 0);
        step();
        chk("wrap_1", stall_cnt_o, 1);
        clr();

        // Randomized traffic; the negedge model checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            step();
            if (n % 250 == 249) begin
                clr();
                rst_n = 0;
                continue;
            end
            rst_n         = 1;
            jump_en_i     = ($urandom % 8) == 0;
            jump_addr_i   = $urandom;
            hold_flag_i   = ($urandom % 8) == 0;
            mdu_req_i     = mdu_req_i ? (($urandom % 4) != 0) : (($urandom % 6) == 0);
            mdu_done_i    = ($urandom % 4) == 0;
            ex_mem_re_i   = $urandom % 2;
            ex_rd_addr_i  = 5'($urandom % 4);
            id_rs1_addr_i = 5'($urandom % 4);
            id_rs2_addr_i = 5'($urandom % 4);
            id_rs1_used_i = $urandom % 2;
            id_rs2_used_i = $urandom % 2;
        end
        step();
        clr();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
